// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared word width, ALU encodings and helpers for the ID/EX stage
package id_ex_stage_pkg;

    localparam int WORD_W = 8;
    localparam logic [WORD_W-1:0] WORD_ZERO = '0;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
    } ex_ctrl_t;

    // A producer is live when it writes and its target is not the hardwired zero register.
    function automatic logic source_live(input logic reg_write,
                                         input logic idx_is_zero,
                                         input logic zero_reg_en);
        return reg_write && !(zero_reg_en && idx_is_zero);
    endfunction

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// rtl/id_ex_stage_fwd_unit.sv - per-operand forwarding mux, EX/MEM over MEM/WB over register data
module fwd_unit
    import id_ex_stage_pkg::*;
#(
    parameter int REG_ADDR_W  = 3,
    parameter bit ZERO_REG_EN = 1'b1
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [WORD_W-1:0]     reg_data,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_reg_write,
    input  logic [WORD_W-1:0]     mem_result,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_reg_write,
    input  logic [WORD_W-1:0]     wb_result,
    output logic [WORD_W-1:0]     fwd_data
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = source_live(mem_reg_write, mem_rd == '0, ZERO_REG_EN) && (mem_rd == rs);
    assign wb_hit  = source_live(wb_reg_write, wb_rd == '0, ZERO_REG_EN) && (wb_rd == rs);

    always_comb begin
        fwd_data = reg_data;
        if (mem_hit) begin
            fwd_data = mem_result;
        end else if (wb_hit) begin
            fwd_data = wb_result;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand forwarding and load-use stall
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int REG_ADDR_W  = 3,
    parameter bit ZERO_REG_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [3:0]            id_alu_ctrl,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [WORD_W-1:0]     id_rs1_data,
    input  logic [WORD_W-1:0]     id_rs2_data,
    input  logic [WORD_W-1:0]     id_imm,
    input  logic                  id_use_imm,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  flush,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_reg_write,
    input  logic [WORD_W-1:0]     mem_result,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_reg_write,
    input  logic [WORD_W-1:0]     wb_result,
    output logic                  stall_o,
    output logic                  ex_valid,
    output logic [3:0]            alu_ctrl,
    output logic [WORD_W-1:0]     alu_a,
    output logic [WORD_W-1:0]     alu_b,
    output logic [WORD_W-1:0]     ex_store_data,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write
);

    logic [REG_ADDR_W-1:0] ex_rs1;
    logic [REG_ADDR_W-1:0] ex_rs2;
    logic [WORD_W-1:0]     ex_rs1_data;
    logic [WORD_W-1:0]     ex_rs2_data;
    logic [WORD_W-1:0]     ex_imm;
    logic                  ex_use_imm;

    logic                  load_use;
    logic                  rs2_used;
    logic                  wb_live;
    logic [WORD_W-1:0]     cap_rs1_data;
    logic [WORD_W-1:0]     cap_rs2_data;
    ex_ctrl_t              cap_ctrl;
    logic [WORD_W-1:0]     fwd1;
    logic [WORD_W-1:0]     fwd2;

    // A load in EX whose result an ID operand needs cannot be forwarded until it reaches MEM.
    assign rs2_used = !id_use_imm || id_mem_write;
    assign load_use = ex_valid && ex_mem_read
                   && source_live(ex_reg_write, ex_rd == '0, ZERO_REG_EN)
                   && id_valid && !flush
                   && ((ex_rd == id_rs1) || ((ex_rd == id_rs2) && rs2_used));
    assign stall_o  = load_use;

    // The regfile write in WB lands on the same edge as capture, so read data may be stale.
    assign wb_live      = source_live(wb_reg_write, wb_rd == '0, ZERO_REG_EN);
    assign cap_rs1_data = (wb_live && (wb_rd == id_rs1)) ? wb_result : id_rs1_data;
    assign cap_rs2_data = (wb_live && (wb_rd == id_rs2)) ? wb_result : id_rs2_data;

    always_comb begin
        cap_ctrl = '0;
        if (id_valid) begin
            cap_ctrl.reg_write = id_reg_write;
            cap_ctrl.mem_read  = id_mem_read;
            cap_ctrl.mem_write = id_mem_write;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush || load_use) begin
            ex_valid     <= 1'b0;
            alu_ctrl     <= 4'b0000;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_rs1_data  <= WORD_ZERO;
            ex_rs2_data  <= WORD_ZERO;
            ex_imm       <= WORD_ZERO;
            ex_use_imm   <= 1'b0;
            ex_rd        <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
        end else begin
            ex_valid     <= id_valid;
            alu_ctrl     <= id_alu_ctrl;
            ex_rs1       <= id_rs1;
            ex_rs2       <= id_rs2;
            ex_rs1_data  <= cap_rs1_data;
            ex_rs2_data  <= cap_rs2_data;
            ex_imm       <= id_imm;
            ex_use_imm   <= id_use_imm;
            ex_rd        <= id_rd;
            ex_reg_write <= cap_ctrl.reg_write;
            ex_mem_read  <= cap_ctrl.mem_read;
            ex_mem_write <= cap_ctrl.mem_write;
        end
    end

    fwd_unit #(
        .REG_ADDR_W (REG_ADDR_W),
        .ZERO_REG_EN(ZERO_REG_EN)
    ) u_fwd_rs1 (
        .rs           (ex_rs1),
        .reg_data     (ex_rs1_data),
        .mem_rd       (mem_rd),
        .mem_reg_write(mem_reg_write),
        .mem_result   (mem_result),
        .wb_rd        (wb_rd),
        .wb_reg_write (wb_reg_write),
        .wb_result    (wb_result),
        .fwd_data     (fwd1)
    );

    fwd_unit #(
        .REG_ADDR_W (REG_ADDR_W),
        .ZERO_REG_EN(ZERO_REG_EN)
    ) u_fwd_rs2 (
        .rs           (ex_rs2),
        .reg_data     (ex_rs2_data),
        .mem_rd       (mem_rd),
        .mem_reg_write(mem_reg_write),
        .mem_result   (mem_result),
        .wb_rd        (wb_rd),
        .wb_reg_write (wb_reg_write),
        .wb_result    (wb_result),
        .fwd_data     (fwd2)
    );

    assign alu_a         = ex_valid ? fwd1 : WORD_ZERO;
    assign alu_b         = ex_valid ? (ex_use_imm ? ex_imm : fwd2) : WORD_ZERO;
    assign ex_store_data = ex_valid ? fwd2 : WORD_ZERO;

endmodule
